maze_player_mover: RTL and testbench

- Player-position controller between the board buttons and maze_renderer_test. Produces the x_coord / y_coord that the renderer draws.
- Reads the carved maze bitmap from maze_carver and moves the player one tile per debounced button press, with auto-repeat while a button is held.
- Rejects moves into walls or off the maze, counts accepted moves, and flags arrival at the goal tile.

---
 rtl/maze_player_mover.sv | 224 ++++++++++++++++++++++
 tb/tb_maze_player_mover.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_player_mover.sv
// ---------------------------------------------------------------------------
// maze_player_mover
//
// Moves the player one tile per debounced button press across the carved maze
// bitmap. While a button is held, the move repeats at a fixed interval. Moves
// into walls or off the active maze area are rejected. The block counts
// accepted moves and flags arrival at the goal tile.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   enable                movement requests are accepted only while high
//   load                  synchronous restart at the (clamped) start tile
//   path_data             bitmap, bit y*MAX_DIM+x = 1 means open path
//   maze_width/height     active columns / rows (1..MAX_DIM)
//   start_x/y, goal_x/y   start tile and goal tile
//   btn_up/down/left/right raw asynchronous push buttons
//   x_coord, y_coord      current player tile
//   moved / blocked       one-cycle pulses for committed / rejected moves
//   at_goal               player is on the goal tile
//   move_count            accepted moves since load/reset, saturating
// ---------------------------------------------------------------------------
module maze_player_mover #(
    parameter int MAX_DIM         = 64,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       load,
    input  logic [MAX_DIM*MAX_DIM-1:0] path_data,
    input  logic [6:0]                 maze_width,
    input  logic [6:0]                 maze_height,
    input  logic [6:0]                 start_x,
    input  logic [6:0]                 start_y,
    input  logic [6:0]                 goal_x,
    input  logic [6:0]                 goal_y,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    output logic [6:0]                 x_coord,
    output logic [6:0]                 y_coord,
    output logic                       moved,
    output logic                       blocked,
    output logic                       at_goal,
    output logic [15:0]                move_count
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM * MAX_DIM) : 1;

    // Button index order doubles as request priority: 0 (up) wins.
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, WON} state_t;

    state_t            state, state_next;
    dir_t              dir_q, req_dir;
    logic [3:0]        btn_raw, sync1, sync2, deb, deb_q, req;
    logic              req_any;
    logic [DB_W-1:0]   db_cnt [4];
    logic [RP_W-1:0]   rp_cnt [4];

    logic [7:0]        tgt_x, tgt_y;
    logic              at_edge, off_maze, target_ok, target_is_goal;
    logic [IDX_W-1:0]  tgt_idx;
    logic [6:0]        width_m1, height_m1, start_cx, start_cy;
    logic              start_is_goal;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchroniser followed by a per-button debounce counter. The
    // counter only runs while the synced level disagrees with the accepted
    // level, so any single agreeing sample restarts the stability window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // A request is a debounced rising edge, or the repeat counter expiring
    // while the button stays held.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i] = (deb[i] & ~deb_q[i]) |
                     (deb[i] & deb_q[i] & (rp_cnt[i] == RP_W'(REPEAT_CYCLES - 1)));
        end
    end

    // Repeat counters restart on release and on every request, so repeats are
    // spaced exactly REPEAT_CYCLES apart even when a request is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rp_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!deb[i] || req[i]) rp_cnt[i] <= '0;
                else                   rp_cnt[i] <= rp_cnt[i] + 1'b1;
            end
        end
    end

    // Fixed priority select; lower-priority simultaneous requests are dropped.
    always_comb begin
        req_any = |req;
        req_dir = DIR_UP;
        if      (req[0]) req_dir = DIR_UP;
        else if (req[1]) req_dir = DIR_DOWN;
        else if (req[2]) req_dir = DIR_LEFT;
        else if (req[3]) req_dir = DIR_RIGHT;
    end

    // Target tile is formed one bit wider than the coordinates so a step
    // past the last column/row cannot wrap back into the maze.
    always_comb begin
        tgt_x   = {1'b0, x_coord};
        tgt_y   = {1'b0, y_coord};
        at_edge = 1'b0;
        case (dir_q)
            DIR_UP: begin
                if (y_coord == 7'd0) at_edge = 1'b1;
                else                 tgt_y   = tgt_y - 8'd1;
            end
            DIR_DOWN:  tgt_y = tgt_y + 8'd1;
            DIR_LEFT: begin
                if (x_coord == 7'd0) at_edge = 1'b1;
                else                 tgt_x   = tgt_x - 8'd1;
            end
            DIR_RIGHT: tgt_x = tgt_x + 8'd1;
        endcase
        off_maze = (tgt_x >= {1'b0, maze_width}) || (tgt_y >= {1'b0, maze_height}) ||
                   (32'(tgt_x) >= MAX_DIM) || (32'(tgt_y) >= MAX_DIM);
        tgt_idx  = IDX_W'(32'(tgt_y) * MAX_DIM + 32'(tgt_x));
        target_ok      = !at_edge && !off_maze && path_data[tgt_idx];
        target_is_goal = (tgt_x[6:0] == goal_x) && (tgt_y[6:0] == goal_y);
    end

    // Start tile clamped into the active maze area.
    always_comb begin
        width_m1      = maze_width - 7'd1;
        height_m1     = maze_height - 7'd1;
        start_cx      = (start_x > width_m1)  ? width_m1  : start_x;
        start_cy      = (start_y > height_m1) ? height_m1 : start_y;
        start_is_goal = (start_cx == goal_x) && (start_cy == goal_y);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and the move/blocked pulses. Load overrides every state and
    // throws away any move still being checked or committed.
    always_comb begin
        state_next = state;
        moved      = 1'b0;
        blocked    = 1'b0;
        case (state)
            IDLE:   if (enable && req_any) state_next = CHECK;
            CHECK: begin
                if (target_ok) begin
                    state_next = COMMIT;
                end else begin
                    blocked    = 1'b1;
                    state_next = IDLE;
                end
            end
            COMMIT: begin
                moved      = 1'b1;
                state_next = at_goal ? WON : IDLE;
            end
            WON:    state_next = WON;
        endcase
        if (load) state_next = start_is_goal ? WON : IDLE;
    end

    // Position, counter and goal flag. The coordinates are written on the
    // edge that enters COMMIT so they appear together with the moved pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_coord    <= '0;
            y_coord    <= '0;
            move_count <= '0;
            at_goal    <= 1'b0;
            dir_q      <= DIR_UP;
        end else if (load) begin
            x_coord    <= start_cx;
            y_coord    <= start_cy;
            move_count <= '0;
            at_goal    <= start_is_goal;
        end else begin
            if (state == IDLE && enable && req_any) dir_q <= req_dir;
            if (state == CHECK && target_ok) begin
                x_coord <= tgt_x[6:0];
                y_coord <= tgt_y[6:0];
                at_goal <= target_is_goal;
                if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_maze_player_mover.sv
// ---------------------------------------------------------------------------
// tb_maze_player_mover
//
// Drives maze_player_mover with directed scenarios followed by randomized
// button/load/enable/maze traffic, and compares every output each cycle with
// a behavioural model that works from button-sample history and scheduled
// move events.
// ---------------------------------------------------------------------------
module tb_maze_player_mover;

    localparam int MAX_DIM = 8;
    localparam int DB      = 4;
    localparam int RP      = 16;
    localparam int BIG     = 32'h3FFF_FFFF;

    logic                       clk = 1'b0;
    logic                       reset, enable, load;
    logic [MAX_DIM*MAX_DIM-1:0] path_data;
    logic [6:0]                 maze_width, maze_height, start_x, start_y, goal_x, goal_y;
    logic                       btn_up, btn_down, btn_left, btn_right;
    logic [6:0]                 x_coord, y_coord;
    logic                       moved, blocked, at_goal;
    logic [15:0]                move_count;

    maze_player_mover #(
        .MAX_DIM(MAX_DIM), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .path_data(path_data), .maze_width(maze_width), .maze_height(maze_height),
        .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .x_coord(x_coord), .y_coord(y_coord), .moved(moved), .blocked(blocked),
        .at_goal(at_goal), .move_count(move_count)
    );

    always #5 clk = ~clk;

    // Values to be driven at the start of the next cycle.
    logic [3:0]                 nx_btn;
    logic                       nx_load, nx_enable;
    logic [MAX_DIM*MAX_DIM-1:0] nx_path;
    logic [6:0]                 nx_w, nx_h, nx_sx, nx_sy, nx_gx, nx_gy;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         cyc;
    logic [DB+1:0] raw_sh [4];
    bit         m_deb [4];
    bit         m_req [4];
    int         m_last [4];
    int         m_x, m_y, m_count;
    bit         m_goal, m_won;
    int         check_cyc, commit_cyc, free_at;
    int         dir_pend, tgt_x, tgt_y;
    bit         exp_moved, exp_blocked;
    int         rst_left;
    bit         rst_in_check;

    localparam logic [3:0] B_UP = 4'b0001, B_DOWN = 4'b0010, B_LEFT = 4'b0100, B_RIGHT = 4'b1000;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            raw_sh[i] = '0;
            m_deb[i]  = 1'b0;
            m_req[i]  = 1'b0;
            m_last[i] = 0;
        end
        m_x = 0; m_y = 0; m_count = 0;
        m_goal = 1'b0; m_won = 1'b0;
        check_cyc = -1; commit_cyc = -1; free_at = 0;
    endtask

    // Effects of a rising clock edge, using the inputs held during the
    // previous cycle.
    task automatic edge_model();
        logic [3:0] raw;
        bit         rose;
        int         w1, h1;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        raw = {btn_right, btn_left, btn_down, btn_up};
        for (int i = 0; i < 4; i++) begin
            raw_sh[i] = {raw_sh[i][DB:0], raw[i]};
            rose = 1'b0;
            // The level seen by the debouncer lags the pin by two edges; it
            // flips once DB such samples in a row disagree with it.
            if (raw_sh[i][DB+1:2] == {DB{~m_deb[i]}}) begin
                m_deb[i] = ~m_deb[i];
                rose     = m_deb[i];
            end
            m_req[i] = 1'b0;
            if (rose) begin
                m_req[i] = 1'b1; m_last[i] = cyc;
            end else if (m_deb[i] && (cyc - m_last[i] == RP)) begin
                m_req[i] = 1'b1; m_last[i] = cyc;
            end
        end
        if (load) begin
            w1 = int'(maze_width) - 1;
            h1 = int'(maze_height) - 1;
            m_x = (int'(start_x) > w1) ? w1 : int'(start_x);
            m_y = (int'(start_y) > h1) ? h1 : int'(start_y);
            m_count = 0;
            m_won   = (m_x == int'(goal_x)) && (m_y == int'(goal_y));
            m_goal  = m_won;
            check_cyc = -1; commit_cyc = -1; free_at = cyc;
        end else if (commit_cyc == cyc) begin
            m_x = tgt_x; m_y = tgt_y;
            if (m_count < 65535) m_count++;
            m_goal = (m_x == int'(goal_x)) && (m_y == int'(goal_y));
            m_won  = m_goal;
            if (!m_won) free_at = cyc + 1;
        end
    endtask

    // Expected behaviour within the current cycle, using the inputs now driven.
    task automatic cycle_model();
        bit valid;
        int tx, ty;
        exp_moved   = (commit_cyc == cyc);
        exp_blocked = 1'b0;
        if (check_cyc == cyc) begin
            tx = m_x + ((dir_pend == 3) ? 1 : (dir_pend == 2) ? -1 : 0);
            ty = m_y + ((dir_pend == 1) ? 1 : (dir_pend == 0) ? -1 : 0);
            valid = (tx >= 0) && (ty >= 0) && (tx < int'(maze_width)) && (ty < int'(maze_height)) &&
                    (tx < MAX_DIM) && (ty < MAX_DIM);
            if (valid) valid = path_data[ty*MAX_DIM + tx];
            if (valid) begin
                tgt_x = tx; tgt_y = ty; commit_cyc = cyc + 1;
            end else begin
                exp_blocked = 1'b1; free_at = cyc + 1;
            end
        end
        if (!m_won && cyc >= free_at && enable) begin
            for (int i = 0; i < 4; i++) begin
                if (m_req[i] && check_cyc != cyc + 1) begin
                    dir_pend = i; check_cyc = cyc + 1; free_at = BIG;
                end
            end
        end
    endtask

    // One full clock cycle: edge, drive, model, then compare at the falling edge.
    task automatic applyStimulus();
        @(posedge clk);
        edge_model();
        #1;
        {btn_right, btn_left, btn_down, btn_up} = nx_btn;
        load = nx_load; enable = nx_enable; path_data = nx_path;
        maze_width = nx_w; maze_height = nx_h;
        start_x = nx_sx; start_y = nx_sy; goal_x = nx_gx; goal_y = nx_gy;
        if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) reset = 1'b0;
        end
        cycle_model();
        if (rst_in_check && check_cyc == cyc) begin
            #1;
            reset = 1'b1;
            rst_left = 3;
            rst_in_check = 1'b0;
            model_reset();
            exp_moved = 1'b0; exp_blocked = 1'b0;
        end
        @(negedge clk);
        checkOutput("x_coord",    32'(x_coord),    32'(m_x));
        checkOutput("y_coord",    32'(y_coord),    32'(m_y));
        checkOutput("moved",      32'(moved),      32'(exp_moved));
        checkOutput("blocked",    32'(blocked),    32'(exp_blocked));
        checkOutput("at_goal",    32'(at_goal),    32'(m_goal));
        checkOutput("move_count", 32'(move_count), 32'(m_count));
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        nx_btn = b;
        repeat (n) applyStimulus();
    endtask

    task automatic do_load(input int sx, input int sy, input int gx, input int gy);
        nx_sx = 7'(sx); nx_sy = 7'(sy); nx_gx = 7'(gx); nx_gy = 7'(gy);
        nx_load = 1'b1;
        nx_btn  = 4'b0000;
        applyStimulus();
        nx_load = 1'b0;
        applyStimulus();
    endtask

    initial begin
        int sel;
        reset = 1'b1; enable = 1'b0; load = 1'b0; path_data = '0;
        maze_width = 7'd8; maze_height = 7'd8;
        start_x = '0; start_y = '0; goal_x = '0; goal_y = '0;
        {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
        nx_btn = '0; nx_load = 1'b0; nx_enable = 1'b1; nx_path = '1;
        nx_w = 7'd8; nx_h = 7'd8; nx_sx = '0; nx_sy = '0; nx_gx = 7'd7; nx_gy = 7'd7;
        cyc = 0; rst_left = 3; rst_in_check = 1'b0;
        model_reset();

        // Reset state, then a clean right press from (1,1).
        hold(4'b0000, 5);
        do_load(1, 1, 7, 7);
        hold(B_RIGHT, 8);
        hold(4'b0000, 8);

        // Bouncing button never reaches a stable debounced level.
        for (int i = 0; i < 5; i++) begin
            hold(B_RIGHT, 2);
            hold(4'b0000, 2);
        end
        hold(4'b0000, 8);

        // Left edge of the maze, then a wall to the right.
        do_load(0, 3, 7, 7);
        hold(B_LEFT, 8);
        hold(4'b0000, 8);
        nx_path[3*MAX_DIM + 1] = 1'b0;
        hold(B_RIGHT, 8);
        hold(4'b0000, 8);
        nx_path = '1;

        // Auto-repeat down an open column, running into the bottom row.
        do_load(2, 0, 7, 7);
        hold(B_DOWN, 60);
        hold(4'b0000, 10);
        hold(B_DOWN, 140);
        hold(4'b0000, 10);

        // Simultaneous up and left: up wins.
        do_load(3, 3, 7, 7);
        hold(B_UP | B_LEFT, 8);
        hold(4'b0000, 8);

        // Reaching the goal, presses ignored afterwards, load restores.
        do_load(3, 1, 4, 1);
        hold(B_RIGHT, 8);
        hold(4'b0000, 4);
        hold(B_LEFT, 8);
        hold(4'b0000, 4);
        do_load(3, 1, 4, 1);
        hold(4'b0000, 3);

        // Clamped start landing on the goal enters the won state directly.
        nx_w = 7'd4; nx_h = 7'd3;
        do_load(9, 9, 3, 2);
        hold(B_UP, 8);
        hold(4'b0000, 4);
        nx_w = 7'd8; nx_h = 7'd8;

        // Asynchronous reset while a move is being checked.
        do_load(3, 1, 7, 7);
        rst_in_check = 1'b1;
        hold(B_DOWN, 10);
        hold(4'b0000, 6);

        // Randomized traffic.
        do_load(0, 0, 7, 7);
        for (int seg = 0; seg < 120; seg++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0) begin
                nx_w = 7'($urandom_range(1, MAX_DIM));
                nx_h = 7'($urandom_range(1, MAX_DIM));
                do_load($urandom_range(0, 9), $urandom_range(0, 9),
                        $urandom_range(0, 7), $urandom_range(0, 7));
            end else if (sel == 1) begin
                nx_path = {$urandom, $urandom} | {$urandom, $urandom};
            end else if (sel == 2) begin
                nx_enable = ($urandom_range(0, 3) != 0);
            end else if (sel == 3) begin
                for (int i = 0; i < 4; i++) begin
                    hold(4'($urandom_range(0, 15)), $urandom_range(1, 3));
                end
            end else begin
                hold(4'(1 << $urandom_range(0, 3)) | ((sel == 4) ? 4'($urandom_range(0, 15)) : 4'b0000),
                     $urandom_range(1, 40));
                hold(4'b0000, $urandom_range(0, 12));
            end
        end
        hold(4'b0000, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
